// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-B stage: source select encoding and the
// registered entry payload held in the output and skid registers.
package alu_pkg;

  localparam int unsigned SEL_WIDTH        = 3;
  localparam int unsigned ENTRY_DATA_WIDTH = 32;
  localparam int unsigned ENTRY_TAG_WIDTH  = 4;

  typedef enum logic [SEL_WIDTH-1:0] {
    SRC_REG   = 3'd0,
    SRC_INC   = 3'd1,
    SRC_SEXT  = 3'd2,
    SRC_BR    = 3'd3,
    SRC_ZEXT  = 3'd4,
    SRC_UPPER = 3'd5
  } src_e;

  // Entry widths track the stage's default DATA_WIDTH / TAG_WIDTH.
  typedef struct packed {
    logic [ENTRY_DATA_WIDTH-1:0] b;
    logic [ENTRY_TAG_WIDTH-1:0]  tag;
    logic                        illegal;
  } entry_t;

endpackage

// File: rtl/imm_extend.sv
// Combinational operand-B source mux: register B, PC increment, and the
// four immediate extension/placement forms. Reserved selects flag illegal.
module imm_extend
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned BR_SHIFT   = 2,
  parameter int unsigned PC_INC     = 4
) (
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic [DATA_WIDTH-1:0] reg_b,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic [DATA_WIDTH-1:0] b_c,
  output logic                  illegal_c
);

  localparam int unsigned UPPER_SHIFT = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] sext;
  logic [DATA_WIDTH-1:0] zext;

  assign sext = DATA_WIDTH'($signed(imm));
  assign zext = DATA_WIDTH'(imm);

  always_comb begin
    b_c       = '0;
    illegal_c = 1'b0;
    case (sel)
      SRC_REG:   b_c = reg_b;
      SRC_INC:   b_c = DATA_WIDTH'(PC_INC);
      SRC_SEXT:  b_c = sext;
      SRC_BR:    b_c = sext << BR_SHIFT;
      SRC_ZEXT:  b_c = zext;
      SRC_UPPER: b_c = zext << UPPER_SHIFT;
      default:   illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_operand_b_stage.sv
// Pipelined ALU operand-B selector: registered output behind a valid/ready
// handshake with a one-entry skid so the execute stage can stall freely.
module alu_operand_b_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ENTRY_DATA_WIDTH,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned BR_SHIFT   = 2,
  parameter int unsigned PC_INC     = 4,
  parameter int unsigned TAG_WIDTH  = ENTRY_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic [DATA_WIDTH-1:0] in_reg_b,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_illegal
);

  logic [DATA_WIDTH-1:0] ext_b_c;
  logic                  ext_illegal_c;
  entry_t                in_entry_c;
  logic                  accept_c;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_d;
  logic   skid_valid, skid_valid_d;

  imm_extend #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH),
    .BR_SHIFT   (BR_SHIFT),
    .PC_INC     (PC_INC)
  ) u_imm_extend (
    .sel       (in_sel),
    .reg_b     (in_reg_b),
    .imm       (in_imm),
    .b_c       (ext_b_c),
    .illegal_c (ext_illegal_c)
  );

  assign in_entry_c.b       = ENTRY_DATA_WIDTH'(ext_b_c);
  assign in_entry_c.tag     = ENTRY_TAG_WIDTH'(in_tag);
  assign in_entry_c.illegal = ext_illegal_c;

  // Output register refills from the skid first to keep FIFO order; an
  // accept can only coincide with an empty skid since in_ready = !skid_valid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid;
    skid_d       = skid_q;
    skid_valid_d = skid_valid;
    accept_c     = in_valid & in_ready;
    if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        out_d       = in_entry_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_d       = in_entry_c;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      out_valid  <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_q      <= out_d;
      out_valid  <= out_valid_d;
      skid_q     <= skid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= ~skid_valid_d;
    end
  end

  assign out_b       = DATA_WIDTH'(out_q.b);
  assign out_tag     = TAG_WIDTH'(out_q.tag);
  assign out_illegal = out_q.illegal;

endmodule
